// File: rtl/rotate_scan_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rotate_scan_sequencer_pkg
// Shared constants and the FSM state type for the frame-level rotate scan
// sequencer and its raster counter.
//   IMAGE_SIZE : square image side in pixels (power of two)
//   COOR_WIDTH : coordinate width, log2(IMAGE_SIZE)
//   ANG_WIDTH  : signed angle width in degrees
//   ADDR_WIDTH : linear source address width, 2*COOR_WIDTH
// -----------------------------------------------------------------------------
package rotate_scan_sequencer_pkg;

    localparam int IMAGE_SIZE = 512;
    localparam int COOR_WIDTH = $clog2(IMAGE_SIZE);
    localparam int ANG_WIDTH  = 9;
    localparam int ADDR_WIDTH = 2 * COOR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_DONE   = 3'd4
    } rot_scan_state_t;

endpackage

// File: rtl/rotate_scan_sequencer_raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// H/V destination raster counter, H fastest. Clear has priority over advance.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : return both counters to zero
//   i_advance    : step to the next pixel (H wraps to 0 and V increments)
//   o_h, o_v     : current coordinate
//   o_last       : current coordinate is the last pixel of the frame
// -----------------------------------------------------------------------------
module raster_counter
    import rotate_scan_sequencer_pkg::*;
#(
    parameter int COOR_WIDTH = rotate_scan_sequencer_pkg::COOR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_advance,
    output logic [COOR_WIDTH-1:0] o_h,
    output logic [COOR_WIDTH-1:0] o_v,
    output logic                  o_last
);

    localparam logic [COOR_WIDTH-1:0] COOR_MAX = {COOR_WIDTH{1'b1}};
    localparam logic [COOR_WIDTH-1:0] COOR_ONE = {{(COOR_WIDTH-1){1'b0}}, 1'b1};

    logic [COOR_WIDTH-1:0] h_q, h_d;
    logic [COOR_WIDTH-1:0] v_q, v_d;

    // Next-coordinate computation: clear, advance with H wrap, or hold.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (i_clear) begin
            h_d = '0;
            v_d = '0;
        end else if (i_advance) begin
            if (h_q == COOR_MAX) begin
                h_d = '0;
                v_d = v_q + COOR_ONE;
            end else begin
                h_d = h_q + COOR_ONE;
                v_d = v_q;
            end
        end else begin
            h_d = h_q;
            v_d = v_q;
        end
    end

    // Coordinate registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign o_h    = h_q;
    assign o_v    = v_q;
    assign o_last = (h_q == COOR_MAX) && (v_q == COOR_MAX);

endmodule

// File: rtl/rotate_scan_sequencer.sv
// -----------------------------------------------------------------------------
// rotate_scan_sequencer
// Walks the destination raster of a frame, issues one rotate request per pixel,
// waits for the rotated source coordinate and hands destination coordinate,
// linear source address and blank flag to the pixel fetcher (valid/ready).
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_frame_start/i_angle : frame request and angle (sampled in IDLE only)
//   i_abort               : synchronous abort back to IDLE
//   o_busy, o_frame_done  : frame activity and one-cycle completion pulse
//   o_rot_*               : request towards the rotator
//   i_rot_*               : rotator result (only looked at while waiting)
//   o_pix_*, i_pix_ready  : downstream pixel handshake
// All outputs are registered.
// -----------------------------------------------------------------------------
module rotate_scan_sequencer
    import rotate_scan_sequencer_pkg::*;
#(
    parameter int IMAGE_SIZE = rotate_scan_sequencer_pkg::IMAGE_SIZE,
    parameter int ANG_WIDTH  = rotate_scan_sequencer_pkg::ANG_WIDTH,
    localparam int COOR_WIDTH = $clog2(IMAGE_SIZE),
    localparam int ADDR_WIDTH = 2 * COOR_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_frame_start,
    input  logic                         i_abort,
    input  logic signed [ANG_WIDTH-1:0]  i_angle,
    output logic                         o_busy,
    output logic                         o_frame_done,
    output logic                         o_rot_start,
    output logic [COOR_WIDTH-1:0]        o_rot_H,
    output logic [COOR_WIDTH-1:0]        o_rot_V,
    output logic signed [ANG_WIDTH-1:0]  o_rot_angle,
    input  logic [COOR_WIDTH-1:0]        i_rot_H,
    input  logic [COOR_WIDTH-1:0]        i_rot_V,
    input  logic                         i_rot_outOfRange,
    input  logic                         i_rot_valid,
    output logic                         o_pix_valid,
    input  logic                         i_pix_ready,
    output logic [COOR_WIDTH-1:0]        o_pix_dst_H,
    output logic [COOR_WIDTH-1:0]        o_pix_dst_V,
    output logic [ADDR_WIDTH-1:0]        o_pix_src_addr,
    output logic                         o_pix_blank
);

    rot_scan_state_t state_q, state_d;

    logic signed [ANG_WIDTH-1:0] angle_q, angle_d;
    logic                        rot_start_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        pix_valid_q;
    logic [COOR_WIDTH-1:0]       dst_h_q;
    logic [COOR_WIDTH-1:0]       dst_v_q;
    logic [ADDR_WIDTH-1:0]       src_addr_q;
    logic                        blank_q;

    logic                        cnt_clear_s;
    logic                        cnt_advance_s;
    logic                        capture_s;
    logic [COOR_WIDTH-1:0]       cnt_h_s;
    logic [COOR_WIDTH-1:0]       cnt_v_s;
    logic                        cnt_last_s;

    raster_counter #(
        .COOR_WIDTH (COOR_WIDTH)
    ) u_raster_counter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (cnt_clear_s),
        .i_advance (cnt_advance_s),
        .o_h       (cnt_h_s),
        .o_v       (cnt_v_s),
        .o_last    (cnt_last_s)
    );

    // FSM next state; abort outranks rotator valid and downstream ready.
    always_comb begin
        state_d       = state_q;
        angle_d       = angle_q;
        cnt_clear_s   = 1'b0;
        cnt_advance_s = 1'b0;
        capture_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_frame_start) begin
                    angle_d     = i_angle;
                    cnt_clear_s = 1'b1;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (i_rot_valid) begin
                    capture_s = 1'b1;
                    state_d   = ST_OUTPUT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_OUTPUT: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (i_pix_ready) begin
                    if (cnt_last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_advance_s = 1'b1;
                        state_d       = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_OUTPUT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and angle registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            angle_q <= '0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
        end
    end

    // Output registers: strobes are decoded from the next state so they line
    // up with the state they belong to; pixel fields are captured once per
    // rotator result and held until the next capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rot_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            dst_h_q     <= '0;
            dst_v_q     <= '0;
            src_addr_q  <= '0;
            blank_q     <= 1'b0;
        end else begin
            rot_start_q <= (state_d == ST_ISSUE);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            pix_valid_q <= (state_d == ST_OUTPUT);
            if (capture_s) begin
                dst_h_q <= cnt_h_s;
                dst_v_q <= cnt_v_s;
                blank_q <= i_rot_outOfRange;
                // V*IMAGE_SIZE + H collapses to a concatenation for a
                // power-of-two side; out-of-range sources read address 0.
                if (i_rot_outOfRange) begin
                    src_addr_q <= '0;
                end else begin
                    src_addr_q <= {i_rot_V, i_rot_H};
                end
            end
        end
    end

    assign o_busy         = busy_q;
    assign o_frame_done   = done_q;
    assign o_rot_start    = rot_start_q;
    assign o_rot_H        = cnt_h_s;
    assign o_rot_V        = cnt_v_s;
    assign o_rot_angle    = angle_q;
    assign o_pix_valid    = pix_valid_q;
    assign o_pix_dst_H    = dst_h_q;
    assign o_pix_dst_V    = dst_v_q;
    assign o_pix_src_addr = src_addr_q;
    assign o_pix_blank    = blank_q;

endmodule

// File: tb/tb_rotate_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rotate_scan_sequencer
// Directed bench for a 4x4 image with an identity rotator model of 3-cycle
// latency. Each scenario task drives its stimulus and checks inline.
// -----------------------------------------------------------------------------
module tb_rotate_scan_sequencer;

    logic              i_clk;
    logic              i_rst;
    logic              i_frame_start;
    logic              i_abort;
    logic signed [8:0] i_angle;
    logic              o_busy;
    logic              o_frame_done;
    logic              o_rot_start;
    logic [1:0]        o_rot_H;
    logic [1:0]        o_rot_V;
    logic signed [8:0] o_rot_angle;
    logic [1:0]        i_rot_H;
    logic [1:0]        i_rot_V;
    logic              i_rot_outOfRange;
    logic              i_rot_valid;
    logic              o_pix_valid;
    logic              i_pix_ready;
    logic [1:0]        o_pix_dst_H;
    logic [1:0]        o_pix_dst_V;
    logic [3:0]        o_pix_src_addr;
    logic              o_pix_blank;

    int   checks;
    int   errors;
    logic oor_origin;

    rotate_scan_sequencer #(
        .IMAGE_SIZE (4),
        .ANG_WIDTH  (9)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_frame_start    (i_frame_start),
        .i_abort          (i_abort),
        .i_angle          (i_angle),
        .o_busy           (o_busy),
        .o_frame_done     (o_frame_done),
        .o_rot_start      (o_rot_start),
        .o_rot_H          (o_rot_H),
        .o_rot_V          (o_rot_V),
        .o_rot_angle      (o_rot_angle),
        .i_rot_H          (i_rot_H),
        .i_rot_V          (i_rot_V),
        .i_rot_outOfRange (i_rot_outOfRange),
        .i_rot_valid      (i_rot_valid),
        .o_pix_valid      (o_pix_valid),
        .i_pix_ready      (i_pix_ready),
        .o_pix_dst_H      (o_pix_dst_H),
        .o_pix_dst_V      (o_pix_dst_V),
        .o_pix_src_addr   (o_pix_src_addr),
        .o_pix_blank      (o_pix_blank)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Rotator model: identity mapping, 3-cycle latency. Out-of-range results
    // carry a deliberately non-zero garbage source coordinate (3,2).
    logic       s1, s2, oor1, oor2;
    logic [1:0] h1, v1, h2, v2;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1 <= 1'b0; s2 <= 1'b0; oor1 <= 1'b0; oor2 <= 1'b0;
            h1 <= 2'd0; v1 <= 2'd0; h2 <= 2'd0; v2 <= 2'd0;
            i_rot_valid <= 1'b0; i_rot_outOfRange <= 1'b0;
            i_rot_H <= 2'd0; i_rot_V <= 2'd0;
        end else begin
            s1   <= o_rot_start;
            oor1 <= oor_origin && (o_rot_H == 2'd0) && (o_rot_V == 2'd0);
            h1   <= o_rot_H;
            v1   <= o_rot_V;
            s2   <= s1;
            oor2 <= oor1;
            h2   <= h1;
            v2   <= v1;
            i_rot_valid      <= s2;
            i_rot_outOfRange <= oor2;
            i_rot_H <= oor2 ? 2'd3 : h2;
            i_rot_V <= oor2 ? 2'd2 : v2;
        end
    end

    // Called 1 time unit after a rising edge with the DUT in IDLE; returns
    // 1 time unit after the edge that accepts the start.
    task automatic start_frame(input logic signed [8:0] ang);
        i_angle       = ang;
        i_frame_start = 1'b1;
        @(posedge i_clk); #1;
        i_frame_start = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_frame_start = 1'b0; i_abort = 1'b0; i_angle = 9'sd0;
        i_pix_ready = 1'b1; oor_origin = 1'b0;
        #3;
        checks++;
        if ({o_busy, o_frame_done, o_rot_start, o_pix_valid, o_pix_blank} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000",
                     {o_busy, o_frame_done, o_rot_start, o_pix_valid, o_pix_blank});
        end
        checks++;
        if ({o_rot_H, o_rot_V, o_pix_dst_H, o_pix_dst_V, o_pix_src_addr, o_rot_angle} !== 21'd0) begin
            errors++;
            $display("FAIL reset_fields: got %h required 0",
                     {o_rot_H, o_rot_V, o_pix_dst_H, o_pix_dst_V, o_pix_src_addr, o_rot_angle});
        end
        #9 i_rst = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        checks++;
        if (o_busy !== 1'b0 || o_rot_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b rot_start=%b required 0 0", o_busy, o_rot_start);
        end
    endtask

    task automatic test_normal_frame();
        int pix, done_cnt, done_at, exp_addr;
        logic [1:0] eh, ev;
        pix = 0; done_cnt = 0; done_at = -1; eh = 2'd0; ev = 2'd0;
        start_frame(9'sd0);
        checks++;
        if (o_rot_start !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL normal_first_issue: got start=%b busy=%b required 1 1", o_rot_start, o_busy);
        end
        for (int e = 1; e <= 100; e++) begin
            @(posedge i_clk); #1;
            if (o_pix_valid) begin
                exp_addr = ev * 4 + eh;
                checks++;
                if (o_pix_dst_H !== eh || o_pix_dst_V !== ev || o_pix_src_addr !== exp_addr[3:0]
                    || o_pix_blank !== 1'b0) begin
                    errors++;
                    $display("FAIL normal_pixel%0d: got dst=(%0d,%0d) addr=%0d blank=%b required (%0d,%0d) %0d 0",
                             pix, o_pix_dst_H, o_pix_dst_V, o_pix_src_addr, o_pix_blank, eh, ev, exp_addr);
                end
                if (eh == 2'd3 && ev == 2'd1) begin
                    checks++;
                    if (o_pix_src_addr !== 4'd7) begin
                        errors++;
                        $display("FAIL normal_addr_3_1: got %0d required 7", o_pix_src_addr);
                    end
                end
                pix++;
                if (eh == 2'd3) begin eh = 2'd0; ev = ev + 2'd1; end
                else begin eh = eh + 2'd1; end
            end
            if (o_frame_done) begin
                done_cnt++;
                if (done_at < 0) done_at = e;
            end
        end
        checks++;
        if (pix !== 16) begin errors++; $display("FAIL normal_pix_count: got %0d required 16", pix); end
        checks++;
        if (done_cnt !== 1 || done_at !== 80) begin
            errors++;
            $display("FAIL normal_done: got count=%0d at=%0d required 1 at 80", done_cnt, done_at);
        end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL normal_idle_busy: got %b required 0", o_busy); end
    endtask

    task automatic test_blank();
        int pix;
        pix = 0; oor_origin = 1'b1;
        start_frame(9'sd90);
        for (int e = 1; e <= 100; e++) begin
            @(posedge i_clk); #1;
            if (o_pix_valid) begin
                checks++;
                if (pix == 0) begin
                    if (o_pix_blank !== 1'b1 || o_pix_src_addr !== 4'd0) begin
                        errors++;
                        $display("FAIL blank_first: got blank=%b addr=%0d required 1 0", o_pix_blank, o_pix_src_addr);
                    end
                end else begin
                    if (o_pix_blank !== 1'b0 || o_pix_src_addr !== 4'(pix)) begin
                        errors++;
                        $display("FAIL blank_rest%0d: got blank=%b addr=%0d required 0 %0d",
                                 pix, o_pix_blank, o_pix_src_addr, pix);
                    end
                end
                pix++;
            end
        end
        oor_origin = 1'b0;
        checks++;
        if (pix !== 16) begin errors++; $display("FAIL blank_pix_count: got %0d required 16", pix); end
    endtask

    task automatic test_backpressure();
        int pix, stall, done_at;
        logic [1:0] hh, hv;
        logic [3:0] ha;
        pix = 0; stall = 0; done_at = -1; hh = 2'd0; hv = 2'd0; ha = 4'd0;
        start_frame(-9'sd45);
        for (int e = 1; e <= 110; e++) begin
            @(posedge i_clk); #1;
            if (o_pix_valid && pix == 4 && stall < 4) begin
                if (stall == 0) begin
                    hh = o_pix_dst_H; hv = o_pix_dst_V; ha = o_pix_src_addr;
                    checks++;
                    if (hh !== 2'd0 || hv !== 2'd1 || ha !== 4'd4) begin
                        errors++;
                        $display("FAIL bp_pixel4: got (%0d,%0d) addr=%0d required (0,1) 4", hh, hv, ha);
                    end
                end else begin
                    checks++;
                    if (o_pix_dst_H !== hh || o_pix_dst_V !== hv || o_pix_src_addr !== ha || o_rot_start !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_stable%0d: got (%0d,%0d) addr=%0d start=%b required (%0d,%0d) %0d 0",
                                 stall, o_pix_dst_H, o_pix_dst_V, o_pix_src_addr, o_rot_start, hh, hv, ha);
                    end
                end
                i_pix_ready = 1'b0;
                stall++;
            end else if (o_pix_valid) begin
                i_pix_ready = 1'b1;
                pix++;
            end else if (stall > 0 && stall < 4) begin
                checks++;
                errors++;
                $display("FAIL bp_valid_dropped: got valid=0 during stall %0d required 1", stall);
                stall = 4;
            end
            if (o_frame_done && done_at < 0) done_at = e;
        end
        i_pix_ready = 1'b1;
        checks++;
        if (pix !== 16 || done_at !== 84) begin
            errors++;
            $display("FAIL bp_done: got pix=%0d done_at=%0d required 16 84", pix, done_at);
        end
    endtask

    task automatic test_ignore_start();
        int pix, done_at;
        pix = 0; done_at = -1;
        start_frame(9'sd37);
        for (int e = 1; e <= 100; e++) begin
            @(posedge i_clk); #1;
            if (e == 30) begin
                i_frame_start = 1'b1; i_angle = -9'sd90;
            end else begin
                i_frame_start = 1'b0;
            end
            if (o_rot_start) begin
                checks++;
                if (o_rot_angle !== 9'sd37) begin
                    errors++;
                    $display("FAIL ignore_angle: got %0d required 37", o_rot_angle);
                end
            end
            if (o_pix_valid) pix++;
            if (o_frame_done && done_at < 0) done_at = e;
        end
        checks++;
        if (pix !== 16 || done_at !== 80) begin
            errors++;
            $display("FAIL ignore_frame: got pix=%0d done_at=%0d required 16 80", pix, done_at);
        end
    endtask

    task automatic test_abort();
        int pix, stray, done_cnt;
        logic aborted, first_seen;
        pix = 0; stray = 0; done_cnt = 0; aborted = 1'b0; first_seen = 1'b0;
        start_frame(9'sd12);
        for (int e = 1; e <= 60 && !aborted; e++) begin
            @(posedge i_clk); #1;
            if (o_pix_valid) pix++;
            if (i_rot_valid && pix == 9) begin
                i_abort = 1'b1;
                @(posedge i_clk); #1;
                i_abort = 1'b0;
                aborted = 1'b1;
                checks++;
                if ({o_busy, o_pix_valid, o_frame_done, o_rot_start} !== 4'b0000) begin
                    errors++;
                    $display("FAIL abort_idle: got busy/valid/done/start=%b required 0000",
                             {o_busy, o_pix_valid, o_frame_done, o_rot_start});
                end
            end
        end
        checks++;
        if (aborted !== 1'b1) begin errors++; $display("FAIL abort_reached: got 0 required 1"); end
        for (int e = 0; e < 10; e++) begin
            @(posedge i_clk); #1;
            if (o_pix_valid || o_frame_done || o_busy) stray++;
        end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles required 0", stray); end
        start_frame(9'sd5);
        checks++;
        if (o_rot_start !== 1'b1 || o_rot_H !== 2'd0 || o_rot_V !== 2'd0 || o_rot_angle !== 9'sd5) begin
            errors++;
            $display("FAIL abort_restart: got start=%b (%0d,%0d) ang=%0d required 1 (0,0) 5",
                     o_rot_start, o_rot_H, o_rot_V, o_rot_angle);
        end
        for (int e = 1; e <= 100; e++) begin
            @(posedge i_clk); #1;
            if (o_pix_valid && !first_seen) begin
                first_seen = 1'b1;
                checks++;
                if (o_pix_dst_H !== 2'd0 || o_pix_dst_V !== 2'd0) begin
                    errors++;
                    $display("FAIL abort_first_pix: got (%0d,%0d) required (0,0)", o_pix_dst_H, o_pix_dst_V);
                end
            end
            if (o_frame_done) done_cnt++;
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL abort_rerun_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_async_reset();
        int pix, quiet, done_at;
        logic stalled;
        pix = 0; quiet = 0; done_at = -1; stalled = 1'b0;
        start_frame(9'sd7);
        for (int e = 1; e <= 60 && !stalled; e++) begin
            @(posedge i_clk); #1;
            if (o_pix_valid && pix == 6) begin
                i_pix_ready = 1'b0;
                stalled = 1'b1;
            end else if (o_pix_valid) begin
                pix++;
            end
        end
        checks++;
        if (stalled !== 1'b1 || o_pix_src_addr !== 4'd6) begin
            errors++;
            $display("FAIL rst_setup: got stalled=%b addr=%0d required 1 6", stalled, o_pix_src_addr);
        end
        #3 i_rst = 1'b1;
        #1;
        checks++;
        if ({o_busy, o_frame_done, o_rot_start, o_pix_valid, o_pix_blank} !== 5'b00000) begin
            errors++;
            $display("FAIL rst_mid_flags: got %b required 00000",
                     {o_busy, o_frame_done, o_rot_start, o_pix_valid, o_pix_blank});
        end
        checks++;
        if ({o_rot_H, o_rot_V, o_pix_dst_H, o_pix_dst_V, o_pix_src_addr, o_rot_angle} !== 21'd0) begin
            errors++;
            $display("FAIL rst_mid_fields: got %h required 0",
                     {o_rot_H, o_rot_V, o_pix_dst_H, o_pix_dst_V, o_pix_src_addr, o_rot_angle});
        end
        #2 i_rst = 1'b0;
        i_pix_ready = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(posedge i_clk); #1;
            if (o_busy || o_rot_start || o_pix_valid || i_rot_valid) quiet++;
        end
        checks++;
        if (quiet !== 0) begin errors++; $display("FAIL rst_await_start: got %0d active cycles required 0", quiet); end
        start_frame(-9'sd180);
        checks++;
        if (o_rot_start !== 1'b1 || o_rot_H !== 2'd0 || o_rot_V !== 2'd0 || o_rot_angle !== -9'sd180) begin
            errors++;
            $display("FAIL rst_restart: got start=%b (%0d,%0d) ang=%0d required 1 (0,0) -180",
                     o_rot_start, o_rot_H, o_rot_V, o_rot_angle);
        end
        for (int e = 1; e <= 100; e++) begin
            @(posedge i_clk); #1;
            if (o_frame_done && done_at < 0) done_at = e;
        end
        checks++;
        if (done_at !== 80) begin errors++; $display("FAIL rst_rerun_done: got %0d required 80", done_at); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_normal_frame();
        test_blank();
        test_backpressure();
        test_ignore_start();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rotate_scan_sequencer.md
Name: rotate_scan_sequencer

Overview:
- Frame-level initiator for the per-pixel coordinate rotator in the frame encoder rotate path.
- On a frame start it latches the angle and walks the destination raster (H fastest, then V).
- For each pixel it issues one rotate request and waits for the result.
- It then emits the destination coordinate, a linear source SRAM address and a blank flag to the downstream pixel fetcher over a valid/ready handshake.

Parameters:
- IMAGE_SIZE, 512, square image side in pixels (power of two).
- COOR_WIDTH, 9, coordinate width; equals log2(IMAGE_SIZE); shared package constant.
- ANG_WIDTH, 9, signed angle width in degrees, range -180..180.
- ADDR_WIDTH, 18, source address width; equals 2*COOR_WIDTH.

Ports:
- i_clk  in  1  single clock
- i_rst  in  1  asynchronous, active-high reset
- i_frame_start  in  1  one-cycle request to begin a frame
- i_abort  in  1  synchronous abort of the current frame
- i_angle  in  ANG_WIDTH signed  rotation angle, sampled on accepted frame start
- o_busy  out  1  high from accepted start until return to IDLE
- o_frame_done  out  1  one-cycle pulse after the last pixel is accepted
- o_rot_start  out  1  one-cycle request pulse to the rotator
- o_rot_H, o_rot_V  out  COOR_WIDTH each  destination coordinate presented to the rotator
- o_rot_angle  out  ANG_WIDTH signed  latched angle
- i_rot_H, i_rot_V  in  COOR_WIDTH each  rotated source coordinate
- i_rot_outOfRange  in  1  source lies outside the image
- i_rot_valid  in  1  rotator result valid
- o_pix_valid  out  1  downstream data valid
- i_pix_ready  in  1  downstream accept
- o_pix_dst_H, o_pix_dst_V  out  COOR_WIDTH each  destination pixel
- o_pix_src_addr  out  ADDR_WIDTH  source address, i_rot_V*IMAGE_SIZE + i_rot_H
- o_pix_blank  out  1  copy of i_rot_outOfRange

Behaviour:
- Reset (async, i_rst=1): state IDLE, all outputs 0, counters 0, latched angle 0.
- FSM states: IDLE, ISSUE, WAIT, OUTPUT, DONE.
- IDLE:
  - i_frame_start=1 -> latch i_angle, H=V=0, go to ISSUE.
  - i_frame_start is ignored in every other state.
- ISSUE:
  - Assert o_rot_start for exactly one cycle, with o_rot_H/o_rot_V/o_rot_angle valid that same cycle.
  - Next state is WAIT.
- WAIT:
  - The first cycle with i_rot_valid=1 registers src_addr and blank, then goes to OUTPUT.
  - i_rot_valid is ignored outside WAIT.
- OUTPUT:
  - o_pix_valid=1 and all o_pix_* fields are held stable until i_pix_ready=1.
  - On acceptance: if H=V=IMAGE_SIZE-1, go to DONE. Otherwise advance H; when H wraps to 0, increment V; go to ISSUE.
- DONE: o_frame_done=1 for one cycle, then IDLE.
- o_busy=1 in ISSUE, WAIT, OUTPUT and DONE.
- Blank pixels: when outOfRange=1, force o_pix_src_addr=0 and o_pix_blank=1.
- Per-pixel minimum cost: 1 (ISSUE) + rotator latency + 1 (OUTPUT with ready high) cycles.
- o_rot_H/o_rot_V are held at the current counters in all states. Outputs are registered; no combinational path from i_pix_ready to o_pix_valid.
- i_abort=1 in any non-IDLE state:
  - next state is IDLE, o_pix_valid and o_rot_start drop, no o_frame_done.
  - i_abort has priority over i_pix_ready and i_rot_valid in the same cycle.
- Address arithmetic is unsigned; the multiply is a concatenation {V,H} because IMAGE_SIZE is a power of two.
- A mid-frame reset returns to IDLE immediately; the rotator is reset by the same signal.

Decomposition:
- Shared package holds IMAGE_SIZE, COOR_WIDTH, ADDR_WIDTH and a state enum typedef rot_scan_state_t.
- One natural sub-module: raster_counter. It is an H/V counter with clear, advance, last-pixel flag and wrap.
- FSM and output registers remain in the top module.

Test Plan:
- IMAGE_SIZE=4 (COOR_WIDTH=2), angle 0, identity bench rotator with 3-cycle latency, ready tied 1:
  - 16 pixels emitted in raster order; dst (3,1) -> src_addr 7, blank 0.
  - o_frame_done pulses once, 16*5 cycles after start.
- Bench rotator flags outOfRange for dst (0,0):
  - first output has blank=1 and src_addr=0.
  - remaining pixels are normal.
- Ready backpressure (ready low 4 cycles on pixel 5):
  - o_pix_valid and fields stay stable; no new o_rot_start is issued until acceptance.
- i_frame_start pulsed mid-frame with a different angle:
  - ignored; o_rot_angle keeps the original value.
- i_abort asserted in WAIT on pixel 9, with a simultaneous i_rot_valid:
  - IDLE next cycle, o_busy=0, no o_pix_valid, no o_frame_done.
  - A new start then begins at (0,0).
- i_rst asserted asynchronously mid-OUTPUT (between clock edges):
  - all outputs 0 immediately.
  - After release, the FSM is in IDLE and awaits i_frame_start.
